gen_crd_arb_top: RTL
====================

// Module: gen_crd_arb_top
// PURPOSE
// - Credit-gated round-robin arbiter: shares one credit-managed downstream target (e.g. a FIFO of CRD_INIT_AMOUNT entries) among NUM_REQ requesters.
// - Issues at most one grant per cycle, and only while a credit exists. Each grant consumes exactly one credit.
// - Downstream returns credits in bulk. A drain FSM quiesces the block for reconfiguration or shutdown.
// PARAMETERS
// - NUM_REQ          4  number of requesters, >=2
// - CRD_INIT_AMOUNT  8  credits loaded at reset (target depth), >=1
// - MAX_CRD_RTRN_VAL 2  max credits returned in one cycle, >=1
// - localparam REQ_IDX_W  = $clog2(NUM_REQ)
// - localparam CRD_CNT_W  = $clog2(CRD_INIT_AMOUNT+1)
// - localparam CRD_RTRN_W = $clog2(MAX_CRD_RTRN_VAL+1)
// PORTS
// - clk           in   1           clock; single clock domain
// - rst           in   1           asynchronous reset, active-high
// - req_vld       in   NUM_REQ     per-requester request, held until granted
// - req_rdy       out  NUM_REQ     one-hot grant; handshake = req_vld[i] & req_rdy[i]
// - gnt_vld       out  1           registered: a grant occurred last cycle
// - gnt_idx       out  REQ_IDX_W   registered: index of last cycle's grantee
// - crd_rtrn_en   in   1           credit return strobe
// - crd_rtrn_val  in   CRD_RTRN_W  credits returned; 0 is legal and is a no-op
// - drain_req     in   1           level; request quiesce
// - drain_done    out  1           drained: no grants, and all credits are home
// - crd_cnt       out  CRD_CNT_W   current credit count (registered)
// - crd_err       out  1           sticky credit overflow flag (see CONFIGURATION)
// BEHAVIOUR
// - Reset values:
//   - crd_cnt = CRD_INIT_AMOUNT; rr_ptr = 0; FSM = RUN.
//   - gnt_vld = 0; gnt_idx = 0; drain_done = 0; crd_err = 0.
//   - req_rdy = 0 while rst is asserted.
// - Arbitration:
//   - req_rdy is combinational from req_vld and registered state.
//   - req_rdy is nonzero only when: FSM == RUN, crd_cnt != 0 and |req_vld.
//   - The winner is the first i with req_vld[i] set, searching from rr_ptr upward with wrap (rr_ptr, rr_ptr+1, ..., NUM_REQ-1, 0, ...).
//   - req_rdy is one-hot or zero. Never drop a request that is not granted.
//   - On a grant: rr_ptr <= winner+1, wrapping NUM_REQ-1 -> 0. With no grant, rr_ptr holds.
//   - gnt_vld and gnt_idx follow the grant with 1-cycle latency.
//   - A single persistent requester is granted on consecutive cycles while credits last.
// - Credits:
//   - Grants use the registered crd_cnt only.
//   - A credit returned in cycle t is grantable in cycle t+1.
//   - The update is evaluated at CRD_CNT_W+1 bits:
//     crd_cnt_next = crd_cnt - gnt + (crd_rtrn_en ? crd_rtrn_val : 0).
//   - A simultaneous grant and return nets in the same cycle. Example: cnt 0 -> no grant possible; cnt 1, grant + return 1 -> 1.
//   - Overflow: if crd_cnt_next > CRD_INIT_AMOUNT, saturate crd_cnt at CRD_INIT_AMOUNT.
//   - Underflow is impossible by construction, since there is no grant at crd_cnt == 0.
// - FSM states: RUN, DRAIN, DONE.
//   - RUN -> DRAIN when drain_req = 1. Grants are blocked from the cycle after drain_req is sampled.
//   - DRAIN -> DONE when crd_cnt == CRD_INIT_AMOUNT. Credit returns are still accepted in DRAIN.
//   - DONE: drain_done = 1 (registered, asserted on entering DONE). DONE -> RUN when drain_req = 0.
//   - drain_req dropped while in DRAIN -> back to RUN; drain_done never pulses.
//   - drain_req high in RUN with crd_cnt already full -> DRAIN for one cycle, then DONE.
// - An async rst mid-operation restores every reset value immediately, including the credit count. Discarding in-flight credits is the owner's responsibility.
// CONFIGURATION
// - Macro: GEN_CRD_ARB_TOP_OVF_CHK_EN.
//   - Defined: crd_err is set when crd_cnt_next > CRD_INIT_AMOUNT. It is sticky until rst. Saturation still applies.
//   - Undefined: crd_err is tied to 0, and the overflow compare logic is not built. Saturation still applies.
// STRUCTURE
// - Package gen_crd_arb_pkg holds:
//   - typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_DONE} crd_arb_st_t;
//   - function rr_next_ptr(idx, num): pointer increment with wrap.
// - Sub-module gen_rr_arb (NUM_REQ param).
//   - Inputs: req, ptr, en. Outputs: one-hot gnt, gnt_idx.
//   - Purely combinational; reusable by other arbiters.
// - Top module holds: credit counter, rr_ptr register, FSM, output registers, optional error flag.
// TESTING
// - Reset (defaults):
//   - Release rst with req_vld=0 -> crd_cnt=8, req_rdy=0, drain_done=0, crd_err=0.
// - Fairness:
//   - req_vld=4'b1111 held, returns 1/cycle from cycle 2 -> req_rdy sequence 0001,0010,0100,1000,0001.
//   - gnt_idx follows one cycle later: 0,1,2,3,0.
// - Exhaustion:
//   - req_vld=4'b0100, no returns -> 8 grants in 8 cycles, then req_rdy=0 and crd_cnt=0.
//   - crd_rtrn_en with val=2 -> the next 2 cycles grant, then stall again.
// - Simultaneous events:
//   - crd_cnt=1, grant plus return val=1 in the same cycle -> crd_cnt stays 1.
//   - crd_cnt=0, return 1 -> no grant this cycle; grant the next cycle.
// - Drain:
//   - 3 credits outstanding, drain_req=1 -> no grants from the next cycle.
//   - Return 2 then 1 -> drain_done rises the cycle after crd_cnt reaches 8.
//   - drain_req=0 -> RUN, and grants resume.
// - Overflow, macro defined:
//   - crd_cnt=7, return val=2 -> crd_cnt=8, crd_err=1, and crd_err stays 1 until rst.
//   - Same stimulus with the macro undefined -> crd_cnt=8, crd_err=0.

Source files
------------

// File: rtl/gen_crd_arb_pkg.sv
// Shared types and helpers for the credit-gated round-robin arbiter.
package gen_crd_arb_pkg;

  typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_DONE} crd_arb_st_t;

  function automatic logic [31:0] rr_next_ptr(input logic [31:0] idx, input logic [31:0] num);
    return (idx >= num - 32'd1) ? 32'd0 : idx + 32'd1;
  endfunction

endpackage

// File: rtl/gen_crd_arb_top_rr.sv
// Combinational round-robin picker: first set request at or after ptr, with wrap.
module gen_rr_arb #(
  parameter int NUM_REQ = 4,
  localparam int IDX_W  = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  input  logic               en,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   gnt_idx
);

  always_comb begin
    int   pos;
    logic found;
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    pos     = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      pos = int'(ptr) + k;
      if (pos >= NUM_REQ) pos = pos - NUM_REQ;
      if (en && !found && req[pos]) begin
        gnt[pos] = 1'b1;
        gnt_idx  = IDX_W'(pos);
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/gen_crd_arb_top.sv
// Credit-gated round-robin arbiter with drain FSM.
// Optional sticky overflow flag: define GEN_CRD_ARB_TOP_OVF_CHK_EN.
//   state    | meaning
//   ST_RUN   | normal arbitration, grants allowed while credits exist
//   ST_DRAIN | grants blocked, waiting for all credits to come home
//   ST_DONE  | quiesced, drain_done asserted until drain_req drops
module gen_crd_arb_top
  import gen_crd_arb_pkg::*;
#(
  parameter int NUM_REQ          = 4,
  parameter int CRD_INIT_AMOUNT  = 8,
  parameter int MAX_CRD_RTRN_VAL = 2,
  localparam int REQ_IDX_W  = $clog2(NUM_REQ),
  localparam int CRD_CNT_W  = $clog2(CRD_INIT_AMOUNT + 1),
  localparam int CRD_RTRN_W = $clog2(MAX_CRD_RTRN_VAL + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_vld,
  output logic [NUM_REQ-1:0]    req_rdy,
  output logic                  gnt_vld,
  output logic [REQ_IDX_W-1:0]  gnt_idx,
  input  logic                  crd_rtrn_en,
  input  logic [CRD_RTRN_W-1:0] crd_rtrn_val,
  input  logic                  drain_req,
  output logic                  drain_done,
  output logic [CRD_CNT_W-1:0]  crd_cnt,
  output logic                  crd_err
);

  localparam int CRD_SUM_W = CRD_CNT_W + 1;

  crd_arb_st_t            st, st_nxt;
  logic [REQ_IDX_W-1:0]   rr_ptr, arb_idx;
  logic [NUM_REQ-1:0]     arb_gnt;
  logic                   arb_en, gnt;
  logic [CRD_SUM_W-1:0]   crd_sum;
  logic                   crd_ovf;

  // rst in the enable keeps req_rdy low during the whole reset pulse
  assign arb_en  = !rst && (st == ST_RUN) && (crd_cnt != '0);
  assign req_rdy = arb_gnt;
  assign gnt     = |arb_gnt;

  gen_rr_arb #(.NUM_REQ(NUM_REQ)) u_rr_arb (
    .req     (req_vld),
    .ptr     (rr_ptr),
    .en      (arb_en),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx)
  );

  assign crd_sum = {1'b0, crd_cnt} - CRD_SUM_W'(gnt)
                 + (crd_rtrn_en ? CRD_SUM_W'(crd_rtrn_val) : '0);
  assign crd_ovf = crd_sum > CRD_SUM_W'(CRD_INIT_AMOUNT);

  always_comb begin
    st_nxt = st;
    case (st)
      ST_RUN:   if (drain_req) st_nxt = ST_DRAIN;
      ST_DRAIN: begin
        if (!drain_req)                                 st_nxt = ST_RUN;
        else if (crd_cnt == CRD_CNT_W'(CRD_INIT_AMOUNT)) st_nxt = ST_DONE;
      end
      ST_DONE:  if (!drain_req) st_nxt = ST_RUN;
      default:  st_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st         <= ST_RUN;
      crd_cnt    <= CRD_CNT_W'(CRD_INIT_AMOUNT);
      rr_ptr     <= '0;
      gnt_vld    <= 1'b0;
      gnt_idx    <= '0;
      drain_done <= 1'b0;
    end else begin
      st         <= st_nxt;
      crd_cnt    <= crd_ovf ? CRD_CNT_W'(CRD_INIT_AMOUNT) : crd_sum[CRD_CNT_W-1:0];
      gnt_vld    <= gnt;
      drain_done <= (st_nxt == ST_DONE);
      if (gnt) begin
        rr_ptr  <= REQ_IDX_W'(rr_next_ptr(32'(arb_idx), 32'(NUM_REQ)));
        gnt_idx <= arb_idx;
      end
    end
  end

`ifdef GEN_CRD_ARB_TOP_OVF_CHK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          crd_err <= 1'b0;
    else if (crd_ovf) crd_err <= 1'b1;
  end
`else
  assign crd_err = 1'b0;
`endif

endmodule
